// File: rtl/adc_capture_if.sv
// Bus-side read and status port of adc_capture.
// The bus master drives the strobes; the capture block returns data and status.
interface adc_capture_if #(
  parameter int DATA_WIDTH = 10,
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  rd_en;
  logic                  flush;
  logic                  ovf_clr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  ovf;

  modport master (
    output rd_en, flush, ovf_clr,
    input  rd_data, rd_valid, fifo_count,
    input  fifo_empty, fifo_full, ovf
  );

  modport slave (
    input  rd_en, flush, ovf_clr,
    output rd_data, rd_valid, fifo_count,
    output fifo_empty, fifo_full, ovf
  );
endinterface

// File: rtl/adc_capture.sv
// Parallel ADC capture: encode clock, warm-up discard and sample FIFO.
// Samples are taken mid low phase and land in the FIFO one cycle later.
module adc_capture #(
  parameter int DATA_WIDTH = 10,
  parameter int CLK_DIV    = 4,
  parameter int WARMUP     = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  enable,
  input  logic                  fmt,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic                  adc_clk,
  output logic                  adc_pwrdn,
  adc_capture_if.slave          bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  localparam logic [DATA_WIDTH-1:0] MSB_MASK =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_RUN
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_d;
  logic [WW-1:0] warm_cnt;
  logic [WW-1:0] warm_d;
  logic          period_end;
  logic          smp_take;

  logic [DATA_WIDTH-1:0] smp_data;
  logic                  smp_vld;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  do_pop;
  logic                  do_wr;
  logic                  ovf_set;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  ovf_q;

  assign period_end = (div_cnt == DW'(CLK_DIV - 1));
  assign smp_take   = (state == S_RUN) && period_end;

  // Next state, warm-up period count and encode divider
  always_comb begin
    state_d = state;
    warm_d  = warm_cnt;
    div_d   = div_cnt;
    unique case (state)
      S_IDLE: begin
        if (enable)
          state_d = (WARMUP == 0) ? S_RUN : S_WARMUP;
      end
      S_WARMUP: begin
        if (period_end) begin
          if (warm_cnt == WW'(WARMUP - 1))
            state_d = S_RUN;
          else
            warm_d = warm_cnt + 1'b1;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
    if (!enable)
      state_d = S_IDLE;
    if (state_d != S_WARMUP)
      warm_d = '0;
    if (state == S_IDLE || state_d == S_IDLE)
      div_d = '0;
    else if (period_end)
      div_d = '0;
    else
      div_d = div_cnt + 1'b1;
  end

  // State, divider and registered ADC control pins
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      warm_cnt  <= '0;
      adc_clk   <= 1'b0;
      adc_pwrdn <= 1'b1;
    end else begin
      state     <= state_d;
      div_cnt   <= div_d;
      warm_cnt  <= warm_d;
      adc_clk   <= (state_d != S_IDLE) &&
                   (div_d < DW'(CLK_DIV / 2));
      adc_pwrdn <= (state_d == S_IDLE);
    end
  end

  // Sample capture with optional offset-binary to two's complement
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      smp_data <= '0;
      smp_vld  <= 1'b0;
    end else begin
      smp_vld <= smp_take;
      if (smp_take)
        smp_data <= fmt ? (adc_data ^ MSB_MASK) : adc_data;
    end
  end

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = bus.rd_en && !empty && !bus.flush;
  assign do_wr   = smp_vld && (!full || do_pop) && !bus.flush;
  assign ovf_set = smp_vld && full && !do_pop && !bus.flush;

  // Sample storage
  always_ff @(posedge sys_clk) begin
    if (do_wr)
      mem[wr_ptr] <= smp_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Read port: data holds its last value between pops
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= do_pop;
      if (do_pop)
        rd_data_q <= mem[rd_ptr];
    end
  end

  // Sticky overflow; a new overflow beats a same-cycle clear
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst)
      ovf_q <= 1'b0;
    else if (ovf_set)
      ovf_q <= 1'b1;
    else if (bus.ovf_clr)
      ovf_q <= 1'b0;
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.fifo_count = count;
  assign bus.fifo_empty = empty;
  assign bus.fifo_full  = full;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture with default parameters.
// Each task drives one scenario and checks its own expectations.
module tb_adc_capture;

  logic       sys_clk;
  logic       sys_rst;
  logic       enable;
  logic       fmt;
  logic [9:0] adc_data;
  logic       adc_clk;
  logic       adc_pwrdn;

  int         n_chk;
  int         n_fail;
  int         per_cnt;
  int         base;
  logic       ramp_on;
  logic [9:0] man_data;
  logic [9:0] exp_d;

  adc_capture_if #(.DATA_WIDTH(10), .FIFO_DEPTH(16)) bus ();

  adc_capture #(
    .DATA_WIDTH(10),
    .CLK_DIV(4),
    .WARMUP(4),
    .FIFO_DEPTH(16)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .enable(enable),
    .fmt(fmt),
    .adc_data(adc_data),
    .adc_clk(adc_clk),
    .adc_pwrdn(adc_pwrdn),
    .bus(bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ADC model: output advances once per encode period
  initial per_cnt = 0;
  always @(posedge adc_clk) per_cnt = per_cnt + 1;

  assign adc_data = ramp_on ? 10'(per_cnt - base - 1) : man_data;

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic start(input logic f);
    base   = per_cnt;
    fmt    = f;
    enable = 1'b1;
  endtask

  task automatic test_reset;
    sys_rst = 1'b1;
    #2;
    sys_rst = 1'b0;
    #10;
    if (adc_clk !== 1'b0) begin
      $display("FAIL rst_adc_clk got=%b exp=0", adc_clk); n_fail++;
    end
    n_chk++;
    if (adc_pwrdn !== 1'b1) begin
      $display("FAIL rst_pwrdn got=%b exp=1", adc_pwrdn); n_fail++;
    end
    n_chk++;
    if (bus.rd_valid !== 1'b0) begin
      $display("FAIL rst_rd_valid got=%b exp=0", bus.rd_valid); n_fail++;
    end
    n_chk++;
    if (bus.rd_data !== 10'h000) begin
      $display("FAIL rst_rd_data got=%h exp=000", bus.rd_data); n_fail++;
    end
    n_chk++;
    if (bus.fifo_count !== 5'd0) begin
      $display("FAIL rst_count got=%0d exp=0", bus.fifo_count); n_fail++;
    end
    n_chk++;
    if (bus.fifo_empty !== 1'b1 || bus.fifo_full !== 1'b0) begin
      $display("FAIL rst_flags got=%b%b exp=10",
               bus.fifo_empty, bus.fifo_full); n_fail++;
    end
    n_chk++;
    if (bus.ovf !== 1'b0) begin
      $display("FAIL rst_ovf got=%b exp=0", bus.ovf); n_fail++;
    end
    n_chk++;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    tick(2);
  endtask

  task automatic test_ramp;
    logic exp_clk;
    ramp_on = 1'b1;
    start(1'b0);
    for (int c = 1; c <= 16; c++) begin
      tick(1);
      exp_clk = ((c - 1) % 4) < 2;
      if (adc_clk !== exp_clk || adc_pwrdn !== 1'b0) begin
        $display("FAIL ramp_clk c=%0d got=%b/%b exp=%b/0",
                 c, adc_clk, adc_pwrdn, exp_clk); n_fail++;
      end
      n_chk++;
    end
    tick(5);
    if (bus.fifo_count !== 5'd0) begin
      $display("FAIL ramp_pre_write got=%0d exp=0", bus.fifo_count);
      n_fail++;
    end
    n_chk++;
    tick(1);
    if (bus.fifo_count !== 5'd1) begin
      $display("FAIL ramp_first_write got=%0d exp=1", bus.fifo_count);
      n_fail++;
    end
    n_chk++;
    tick(12);
    if (bus.fifo_count !== 5'd4) begin
      $display("FAIL ramp_count4 got=%0d exp=4", bus.fifo_count);
      n_fail++;
    end
    n_chk++;
    enable = 1'b0;
    tick(1);
    if (adc_pwrdn !== 1'b1 || adc_clk !== 1'b0) begin
      $display("FAIL ramp_idle got=%b/%b exp=1/0", adc_pwrdn, adc_clk);
      n_fail++;
    end
    n_chk++;
    for (int i = 0; i < 4; i++) begin
      bus.rd_en = 1'b1;
      tick(1);
      bus.rd_en = 1'b0;
      exp_d = 10'(4 + i);
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_d) begin
        $display("FAIL ramp_read%0d got=%b/%h exp=1/%h",
                 i, bus.rd_valid, bus.rd_data, exp_d); n_fail++;
      end
      n_chk++;
    end
    tick(1);
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 10'h007) begin
      $display("FAIL ramp_hold got=%b/%h exp=0/007",
               bus.rd_valid, bus.rd_data); n_fail++;
    end
    n_chk++;
    if (bus.fifo_empty !== 1'b1) begin
      $display("FAIL ramp_empty got=%b exp=1", bus.fifo_empty); n_fail++;
    end
    n_chk++;
    tick(2);
  endtask

  task automatic test_fmt;
    ramp_on  = 1'b0;
    man_data = 10'h200;
    start(1'b1);
    tick(22);
    man_data = 10'h000;
    tick(3);
    enable = 1'b0;
    tick(1);
    if (bus.fifo_count !== 5'd2) begin
      $display("FAIL fmt_pending_write got=%0d exp=2", bus.fifo_count);
      n_fail++;
    end
    n_chk++;
    bus.rd_en = 1'b1;
    tick(1);
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 10'h000) begin
      $display("FAIL fmt_200 got=%b/%h exp=1/000",
               bus.rd_valid, bus.rd_data); n_fail++;
    end
    n_chk++;
    tick(1);
    bus.rd_en = 1'b0;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 10'h200) begin
      $display("FAIL fmt_000 got=%b/%h exp=1/200",
               bus.rd_valid, bus.rd_data); n_fail++;
    end
    n_chk++;
    fmt     = 1'b0;
    ramp_on = 1'b1;
    tick(2);
  endtask

  task automatic test_overflow;
    start(1'b0);
    tick(82);
    if (bus.fifo_count !== 5'd16 || bus.fifo_full !== 1'b1 ||
        bus.ovf !== 1'b0) begin
      $display("FAIL ovf_at_full got=%0d/%b/%b exp=16/1/0",
               bus.fifo_count, bus.fifo_full, bus.ovf); n_fail++;
    end
    n_chk++;
    tick(3);
    bus.ovf_clr = 1'b1;
    tick(1);
    bus.ovf_clr = 1'b0;
    enable = 1'b0;
    if (bus.ovf !== 1'b1 || bus.fifo_count !== 5'd16 ||
        bus.fifo_full !== 1'b1) begin
      $display("FAIL ovf_set got=%b/%0d/%b exp=1/16/1",
               bus.ovf, bus.fifo_count, bus.fifo_full); n_fail++;
    end
    n_chk++;
    for (int i = 0; i < 16; i++) begin
      bus.rd_en = 1'b1;
      tick(1);
      exp_d = 10'(4 + i);
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_d) begin
        $display("FAIL ovf_read%0d got=%b/%h exp=1/%h",
                 i, bus.rd_valid, bus.rd_data, exp_d); n_fail++;
      end
      n_chk++;
    end
    bus.rd_en = 1'b0;
    tick(1);
    if (bus.fifo_empty !== 1'b1 || bus.ovf !== 1'b1) begin
      $display("FAIL ovf_drained got=%b/%b exp=1/1",
               bus.fifo_empty, bus.ovf); n_fail++;
    end
    n_chk++;
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    if (bus.rd_valid !== 1'b0 || bus.fifo_count !== 5'd0 ||
        bus.rd_data !== 10'h013) begin
      $display("FAIL empty_read got=%b/%0d/%h exp=0/0/013",
               bus.rd_valid, bus.fifo_count, bus.rd_data); n_fail++;
    end
    n_chk++;
    bus.ovf_clr = 1'b1;
    tick(1);
    bus.ovf_clr = 1'b0;
    if (bus.ovf !== 1'b0) begin
      $display("FAIL ovf_clr got=%b exp=0", bus.ovf); n_fail++;
    end
    n_chk++;
    tick(2);
  endtask

  task automatic test_back_to_back;
    start(1'b0);
    tick(85);
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    enable = 1'b0;
    if (bus.fifo_count !== 5'd16 || bus.ovf !== 1'b0) begin
      $display("FAIL b2b_count got=%0d/%b exp=16/0",
               bus.fifo_count, bus.ovf); n_fail++;
    end
    n_chk++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 10'h004) begin
      $display("FAIL b2b_pop got=%b/%h exp=1/004",
               bus.rd_valid, bus.rd_data); n_fail++;
    end
    n_chk++;
    for (int i = 0; i < 16; i++) begin
      bus.rd_en = 1'b1;
      tick(1);
      exp_d = 10'(5 + i);
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_d) begin
        $display("FAIL b2b_read%0d got=%b/%h exp=1/%h",
                 i, bus.rd_valid, bus.rd_data, exp_d); n_fail++;
      end
      n_chk++;
    end
    bus.rd_en = 1'b0;
    tick(2);
  endtask

  task automatic test_flush;
    start(1'b0);
    tick(38);
    if (bus.fifo_count !== 5'd5) begin
      $display("FAIL flush_pre got=%0d exp=5", bus.fifo_count); n_fail++;
    end
    n_chk++;
    tick(3);
    bus.flush = 1'b1;
    bus.rd_en = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    bus.rd_en = 1'b0;
    enable    = 1'b0;
    if (bus.fifo_count !== 5'd0 || bus.fifo_empty !== 1'b1 ||
        bus.rd_valid !== 1'b0) begin
      $display("FAIL flush got=%0d/%b/%b exp=0/1/0",
               bus.fifo_count, bus.fifo_empty, bus.rd_valid); n_fail++;
    end
    n_chk++;
    tick(4);
    if (bus.fifo_count !== 5'd0) begin
      $display("FAIL flush_after got=%0d exp=0", bus.fifo_count);
      n_fail++;
    end
    n_chk++;
    tick(2);
  endtask

  task automatic test_reset_mid_run;
    start(1'b0);
    tick(50);
    if (bus.fifo_count !== 5'd8) begin
      $display("FAIL mid_pre got=%0d exp=8", bus.fifo_count); n_fail++;
    end
    n_chk++;
    #1;
    sys_rst = 1'b0;
    #1;
    if (adc_clk !== 1'b0 || adc_pwrdn !== 1'b1) begin
      $display("FAIL mid_rst_pins got=%b/%b exp=0/1", adc_clk, adc_pwrdn);
      n_fail++;
    end
    n_chk++;
    if (bus.fifo_count !== 5'd0 || bus.fifo_empty !== 1'b1 ||
        bus.fifo_full !== 1'b0) begin
      $display("FAIL mid_rst_fifo got=%0d/%b/%b exp=0/1/0",
               bus.fifo_count, bus.fifo_empty, bus.fifo_full); n_fail++;
    end
    n_chk++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 10'h000 ||
        bus.ovf !== 1'b0) begin
      $display("FAIL mid_rst_rd got=%b/%h/%b exp=0/000/0",
               bus.rd_valid, bus.rd_data, bus.ovf); n_fail++;
    end
    n_chk++;
    #3;
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    if (adc_pwrdn !== 1'b0 || adc_clk !== 1'b1 ||
        bus.fifo_count !== 5'd0) begin
      $display("FAIL mid_restart got=%b/%b/%0d exp=0/1/0",
               adc_pwrdn, adc_clk, bus.fifo_count); n_fail++;
    end
    n_chk++;
    tick(2);
    if (adc_clk !== 1'b0) begin
      $display("FAIL mid_warm_clk got=%b exp=0", adc_clk); n_fail++;
    end
    n_chk++;
    enable = 1'b0;
    tick(2);
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    base        = 0;
    ramp_on     = 1'b1;
    man_data    = 10'h000;
    enable      = 1'b0;
    fmt         = 1'b0;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    bus.ovf_clr = 1'b0;
    test_reset;
    test_ramp;
    test_fmt;
    test_overflow;
    test_back_to_back;
    test_flush;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, ADC sample width.
REQ-002 SHALL have parameter CLK_DIV, default 4, sys_clk cycles per ADC encode clock period; even, >=2.
REQ-003 SHALL have parameter WARMUP, default 4, encode periods discarded after enable (ADC pipeline latency).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, sample buffer depth; power of 2.
REQ-005 SHALL have port sys_clk  in  1  single clock for the block; all logic on its rising edge.
REQ-006 SHALL have port sys_rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port enable  in  1  capture enable level.
REQ-008 SHALL have port fmt  in  1  0 = pass offset-binary, 1 = convert to two's complement (MSB inverted).
REQ-009 SHALL have port adc_data  in  DATA_WIDTH  parallel ADC output bus.
REQ-010 SHALL have port adc_clk  out  1  encode clock to ADC.
REQ-011 SHALL have port adc_pwrdn  out  1  ADC power-down, high when not capturing.
REQ-012 SHALL have port rd_en  in  1  single-cycle read request from bus side.
REQ-013 SHALL have port rd_data  out  DATA_WIDTH  popped sample.
REQ-014 SHALL have port rd_valid  out  1  rd_data valid strobe, one cycle.
REQ-015 SHALL have port flush  in  1  single-cycle FIFO clear.
REQ-016 SHALL have port ovf_clr  in  1  single-cycle clear of overflow flag.
REQ-017 SHALL have port fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy.
REQ-018 SHALL have port fifo_empty, fifo_full, ovf  out  1 each  status; ovf sticky.

Function
REQ-019 SHALL implement FSM IDLE -> WARMUP -> RUN; enable=1 in IDLE -> WARMUP; WARMUP -> RUN after WARMUP complete encode periods; enable=0 in any state -> IDLE next cycle.
REQ-020 SHALL in IDLE hold div_cnt=0, adc_clk=0, adc_pwrdn=1; adc_pwrdn=0 in WARMUP and RUN.
REQ-021 SHALL in WARMUP/RUN count div_cnt 0..CLK_DIV-1 wrapping; adc_clk registered, high while div_cnt < CLK_DIV/2.
REQ-022 SHALL sample adc_data on the cycle div_cnt==CLK_DIV-1 (mid low phase), RUN only; WARMUP samples discarded.
REQ-023 SHALL apply fmt conversion at sample time and write the sample into FIFO the following cycle (sample-to-FIFO latency 1 cycle).
REQ-024 SHALL on rd_en with fifo non-empty pop the oldest sample: rd_data and rd_valid=1 on the next cycle; rd_valid=0 otherwise; rd_data holds last value.
REQ-025 SHALL ignore rd_en when empty: no pointer change, rd_valid stays 0, no error flag.
REQ-026 SHALL, on write into full FIFO with no same-cycle pop, drop the sample, keep contents, set ovf.
REQ-027 SHALL, on simultaneous write and pop (including when full), perform both; fifo_count unchanged.
REQ-028 SHALL clear ovf on ovf_clr; if ovf set and ovf_clr occur same cycle, ovf ends 1.
REQ-029 SHALL on flush reset pointers and count to 0 next cycle; flush dominates same-cycle write and pop (rd_valid 0).
REQ-030 SHALL retain FIFO contents and ovf when enable drops; a pending sample write (REQ-023) still completes.
REQ-031 SHALL wrap pointers modulo FIFO_DEPTH; fifo_full when count==FIFO_DEPTH, fifo_empty when count==0.

Reset
REQ-032 SHALL on sys_rst=0 immediately force: state IDLE, div_cnt=0, adc_clk=0, adc_pwrdn=1, rd_valid=0, rd_data=0, fifo_count=0, fifo_empty=1, fifo_full=0, ovf=0.
REQ-033 SHALL resume on first sys_clk edge after sys_rst rises; reset mid-capture discards all buffered samples.

Verification
REQ-034 Bench SHALL cover: enable=1, adc_data ramp 0,1,2... per encode period -> adc_clk period 4 cycles, first 4 periods discarded, FIFO receives consecutive ramp values, first write 1 cycle after sample edge.
REQ-035 Bench SHALL cover: fmt=1, adc_data=10'h200 -> rd_data=10'h000; adc_data=10'h000 -> rd_data=10'h200.
REQ-036 Bench SHALL cover: 17 samples, no reads -> fifo_full=1, ovf=1, count=16; reads return samples 1-16, 17th absent; ovf_clr -> ovf=0.
REQ-037 Bench SHALL cover: full FIFO, pop coinciding with write -> count stays 16, ovf stays 0, rd_valid=1 next cycle.
REQ-038 Bench SHALL cover: rd_en on empty -> rd_valid=0; flush with 5 buffered -> count=0, empty=1 next cycle.
REQ-039 Bench SHALL cover: sys_rst low mid-RUN with 8 buffered -> all outputs at REQ-032 values without clock edge; enable held -> WARMUP restarts after release.
